// File: rtl/edge_detect_bank_if.sv
// Bundle of the monitored lines, per-channel controls and detector outputs.
// These are plain level signals with no valid/ready handshake: the master
// drives sig_in/mode/flag_clr/cnt_clr every cycle, and the slave (the detector)
// presents its registered results every cycle. Nothing is ever back-pressured.
interface edge_detect_bank_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       sig_in;
  logic [2*NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]       flag_clr;
  logic [NUM_CH-1:0]       cnt_clr;
  logic [NUM_CH-1:0]       edge_pls;
  logic [NUM_CH-1:0]       rise_pls;
  logic [NUM_CH-1:0]       fall_pls;
  logic [NUM_CH-1:0]       flag;
  logic [CNT_W*NUM_CH-1:0] count;
  logic                    any_evt;

  modport master (
    output sig_in, mode, flag_clr, cnt_clr,
    input  edge_pls, rise_pls, fall_pls, flag, count, any_evt
  );

  modport slave (
    input  sig_in, mode, flag_clr, cnt_clr,
    output edge_pls, rise_pls, fall_pls, flag, count, any_evt
  );
endinterface

// File: rtl/edge_detect_bank.sv
// Multi-channel edge detector: optional synchroniser, per-channel edge mode,
// one-cycle registered pulses, sticky flags and saturating edge counters.
// A shared warm-up FSM suppresses detection until the synchroniser and the
// previous-sample register hold real data, so lines already high at reset
// release never produce a spurious rising edge.
module edge_detect_bank #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  edge_detect_bank_if.slave  bus_if,
  output logic               dbg_armed_o
);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_ARMED  = 1'b1
  } state_e;

  localparam logic [1:0]       WARM_LAST = 2'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [1:0]        warm_q, warm_d;
  logic              armed;

  logic [NUM_CH-1:0] d;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] rise_d, fall_d, edge_d;
  logic [NUM_CH-1:0] rise_q, fall_q, edge_q;
  logic [NUM_CH-1:0] flag_q, flag_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Synchroniser chain; with zero stages the input is used as-is.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign d = bus_if.sig_in;
  end else begin : g_sync
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

    // Shift the raw inputs through SYNC_STAGES flops.
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= bus_if.sig_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign d = sync_q[SYNC_STAGES-1];
  end

  // Arming FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_WARMUP;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // Arming FSM next state: SYNC_STAGES+1 warm-up clocks, then armed until reset.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      ST_WARMUP: begin
        if (warm_q == WARM_LAST) state_d = ST_ARMED;
        else                     warm_d  = warm_q + 2'd1;
      end
      ST_ARMED: state_d = ST_ARMED;
      default:  state_d = ST_WARMUP;
    endcase
  end

  assign armed       = (state_q == ST_ARMED);
  assign dbg_armed_o = armed;

  // Mode-qualified edge detection against the previous sample.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rise_d[i] = d[i] & ~prev_q[i] & bus_if.mode[2*i];
      fall_d[i] = ~d[i] & prev_q[i] & bus_if.mode[2*i+1];
    end
    edge_d = rise_d | fall_d;
  end

  // Sticky flag and saturating counter next values; a coincident edge beats a clear.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < NUM_CH; i++) cnt_d[i] = cnt_q[i];
    if (armed) begin
      flag_d = edge_d | (flag_q & ~bus_if.flag_clr);
      for (int i = 0; i < NUM_CH; i++) begin
        if (edge_d[i]) begin
          if (bus_if.cnt_clr[i])       cnt_d[i] = CNT_W'(1);
          else if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else if (bus_if.cnt_clr[i]) begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Previous sample always tracks; pulses, flags and counters only move when armed.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      edge_q <= '0;
      flag_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      prev_q <= d;
      rise_q <= {NUM_CH{armed}} & rise_d;
      fall_q <= {NUM_CH{armed}} & fall_d;
      edge_q <= {NUM_CH{armed}} & edge_d;
      flag_q <= flag_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Pack per-channel counters onto the flat output bus.
  always_comb begin
    bus_if.count = '0;
    for (int i = 0; i < NUM_CH; i++) bus_if.count[CNT_W*i +: CNT_W] = cnt_q[i];
  end

  assign bus_if.rise_pls = rise_q;
  assign bus_if.fall_pls = fall_q;
  assign bus_if.edge_pls = edge_q;
  assign bus_if.flag     = flag_q;
  assign bus_if.any_evt  = |edge_q;

endmodule

// File: tb/tb_edge_detect_bank.sv
// Bench for edge_detect_bank: three instances share one stimulus stream
//   a: SYNC_STAGES=2, CNT_W=8   b: SYNC_STAGES=0, CNT_W=8   c: SYNC_STAGES=1, CNT_W=2
// and are checked every cycle against a history-based reference model.
module tb_edge_detect_bank;

  localparam int NCH = 8;
  localparam int S_OF  [3] = '{2, 0, 1};
  localparam int CW_OF [3] = '{8, 8, 2};

  // ---------------- clock / reset ----------------
  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [NCH-1:0]   sig_in   = '0;
  logic [2*NCH-1:0] mode     = '0;
  logic [NCH-1:0]   flag_clr = '0;
  logic [NCH-1:0]   cnt_clr  = '0;
  logic dbg_a, dbg_b, dbg_c;

  edge_detect_bank_if #(.NUM_CH(NCH), .CNT_W(8)) if_a ();
  edge_detect_bank_if #(.NUM_CH(NCH), .CNT_W(8)) if_b ();
  edge_detect_bank_if #(.NUM_CH(NCH), .CNT_W(2)) if_c ();

  assign if_a.sig_in = sig_in;   assign if_a.mode = mode;
  assign if_a.flag_clr = flag_clr; assign if_a.cnt_clr = cnt_clr;
  assign if_b.sig_in = sig_in;   assign if_b.mode = mode;
  assign if_b.flag_clr = flag_clr; assign if_b.cnt_clr = cnt_clr;
  assign if_c.sig_in = sig_in;   assign if_c.mode = mode;
  assign if_c.flag_clr = flag_clr; assign if_c.cnt_clr = cnt_clr;

  edge_detect_bank #(.NUM_CH(NCH), .SYNC_STAGES(2), .CNT_W(8)) u_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus_if(if_a), .dbg_armed_o(dbg_a));
  edge_detect_bank #(.NUM_CH(NCH), .SYNC_STAGES(0), .CNT_W(8)) u_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus_if(if_b), .dbg_armed_o(dbg_b));
  edge_detect_bank #(.NUM_CH(NCH), .SYNC_STAGES(1), .CNT_W(2)) u_c (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus_if(if_c), .dbg_armed_o(dbg_c));

  // ---------------- reference model ----------------
  // in_hist[j] is the sig_in value set up before edge j after reset release.
  // An instance with S stages sees in_hist[k-S] at edge k and in_hist[k-1-S]
  // as its previous sample; it is live from edge S+1 onwards.
  logic [NCH-1:0] in_hist [$];
  int             k;
  logic [NCH-1:0] exp_rise [3];
  logic [NCH-1:0] exp_fall [3];
  logic [NCH-1:0] exp_edge [3];
  logic [NCH-1:0] exp_flag [3];
  logic           exp_arm  [3];
  int             exp_cnt  [3][NCH];

  int passes = 0;
  int total  = 0;

  function automatic logic hbit(int j, int c);
    logic [NCH-1:0] v;
    if (j < 0) return 1'b0;
    v = in_hist[j];
    return v[c];
  endfunction

  task automatic model_reset();
    in_hist.delete();
    k = 0;
    for (int n = 0; n < 3; n++) begin
      exp_rise[n] = '0; exp_fall[n] = '0; exp_edge[n] = '0;
      exp_flag[n] = '0; exp_arm[n] = 1'b0;
      for (int c = 0; c < NCH; c++) exp_cnt[n][c] = 0;
    end
  endtask

  task automatic model_edge();
    int s, maxv;
    logic live, dn, pv, r, f;
    in_hist.push_back(sig_in);
    for (int n = 0; n < 3; n++) begin
      s    = S_OF[n];
      maxv = (1 << CW_OF[n]) - 1;
      live = (k >= s + 1);
      for (int c = 0; c < NCH; c++) begin
        dn = hbit(k - s, c);
        pv = hbit(k - 1 - s, c);
        r  = live && dn && !pv && mode[2*c];
        f  = live && !dn && pv && mode[2*c+1];
        exp_rise[n][c] = r;
        exp_fall[n][c] = f;
        exp_edge[n][c] = r | f;
        if (live) begin
          if (r | f) begin
            exp_flag[n][c] = 1'b1;
            if (cnt_clr[c])              exp_cnt[n][c] = 1;
            else if (exp_cnt[n][c] < maxv) exp_cnt[n][c] = exp_cnt[n][c] + 1;
          end else begin
            if (flag_clr[c]) exp_flag[n][c] = 1'b0;
            if (cnt_clr[c])  exp_cnt[n][c]  = 0;
          end
        end
      end
      exp_arm[n] = (k >= s);
    end
    k++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic check_inst(input int n, input logic [NCH-1:0] e, input logic [NCH-1:0] r,
                            input logic [NCH-1:0] f, input logic [NCH-1:0] fl,
                            input logic [63:0] cnt, input logic any, input logic arm);
    logic [63:0] ecnt;
    ecnt = '0;
    for (int c = 0; c < NCH; c++) ecnt = ecnt | (64'(exp_cnt[n][c]) << (CW_OF[n] * c));
    chk($sformatf("edge_pls_%0d_k%0d", n, k - 1), 64'(e),   64'(exp_edge[n]));
    chk($sformatf("rise_pls_%0d_k%0d", n, k - 1), 64'(r),   64'(exp_rise[n]));
    chk($sformatf("fall_pls_%0d_k%0d", n, k - 1), 64'(f),   64'(exp_fall[n]));
    chk($sformatf("flag_%0d_k%0d", n, k - 1),     64'(fl),  64'(exp_flag[n]));
    chk($sformatf("count_%0d_k%0d", n, k - 1),    cnt,      ecnt);
    chk($sformatf("any_evt_%0d_k%0d", n, k - 1),  64'(any), 64'(|exp_edge[n]));
    chk($sformatf("armed_%0d_k%0d", n, k - 1),    64'(arm), 64'(exp_arm[n]));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model the edge with the current inputs, then compare after it.
  task automatic step();
    model_edge();
    @(posedge ACLK);
    #1;
    check_inst(0, if_a.edge_pls, if_a.rise_pls, if_a.fall_pls, if_a.flag,
               64'(if_a.count), if_a.any_evt, dbg_a);
    check_inst(1, if_b.edge_pls, if_b.rise_pls, if_b.fall_pls, if_b.flag,
               64'(if_b.count), if_b.any_evt, dbg_b);
    check_inst(2, if_c.edge_pls, if_c.rise_pls, if_c.fall_pls, if_c.flag,
               64'(if_c.count), if_c.any_evt, dbg_c);
  endtask

  // Assert reset between clock edges and check that outputs clear without a clock.
  task automatic do_reset();
    #1;
    ARESETN = 1'b0;
    #1;
    chk("async_edge_a",  64'(if_a.edge_pls), 64'd0);
    chk("async_flag_a",  64'(if_a.flag),     64'd0);
    chk("async_count_a", 64'(if_a.count),    64'd0);
    chk("async_edge_b",  64'(if_b.edge_pls), 64'd0);
    chk("async_flag_b",  64'(if_b.flag),     64'd0);
    chk("async_count_b", 64'(if_b.count),    64'd0);
    chk("async_any_b",   64'(if_b.any_evt),  64'd0);
    chk("async_count_c", 64'(if_c.count),    64'd0);
    chk("async_armed_c", 64'(dbg_c),         64'd0);
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic release_reset();
    ARESETN = 1'b1;
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    int hits, when;
    model_reset();

    // Lines held high through reset release: no pulses, counters and flags stay 0.
    sig_in = '1;
    mode   = '1;
    repeat (2) @(posedge ACLK);
    #1;
    release_reset();
    hits = 0;
    repeat (20) begin
      step();
      hits += int'(if_a.any_evt) + int'(if_b.any_evt) + int'(if_c.any_evt);
    end
    chk("t2_pulses", 64'(hits), 64'd0);
    chk("t2_count_a", 64'(if_a.count), 64'd0);
    chk("t2_flag_b", 64'(if_b.flag), 64'd0);

    // Channel 0 rising edge set up before edge 10; instance a pulses after edge 12.
    sig_in = '0;
    do_reset();
    mode = 16'h0001;
    release_reset();
    repeat (10) step();
    sig_in[0] = 1'b1;
    hits = 0;
    when = -1;
    repeat (8) begin
      step();
      if (if_a.rise_pls[0] && if_a.edge_pls[0]) begin
        hits++;
        when = k - 1;
      end
    end
    chk("t1_pulse_edge", 64'(when), 64'd12);
    chk("t1_pulse_cnt", 64'(hits), 64'd1);
    chk("t1_count_a0", 64'(if_a.count[7:0]), 64'd1);
    chk("t1_flag_a0", 64'(if_a.flag[0]), 64'd1);

    // Channel 1 in both-edge mode toggling every cycle.
    sig_in = '0;
    do_reset();
    mode = 16'h000C;
    release_reset();
    repeat (4) step();
    hits = 0;
    repeat (10) begin
      sig_in[1] = ~sig_in[1];
      step();
      hits += int'(if_b.edge_pls[1]);
    end
    chk("t3_edges_b1", 64'(hits), 64'd10);
    chk("t3_count_b1", 64'(if_b.count[15:8]), 64'd10);
    repeat (2) step();

    // Channel 2 counter saturation in the 2-bit instance, then clear with a coincident edge.
    mode[5:4] = 2'b01;
    repeat (5) begin
      sig_in[2] = 1'b1; step();
      sig_in[2] = 1'b0; step();
    end
    repeat (2) step();
    chk("t4_sat_c2", 64'(if_c.count[5:4]), 64'd3);
    sig_in[2] = 1'b1;
    step();
    cnt_clr[2] = 1'b1;
    step();
    cnt_clr[2] = 1'b0;
    chk("t4_clr_edge_c2", 64'(if_c.count[5:4]), 64'd1);

    // Channel 3 flag: a clear coinciding with a new edge loses; a lone clear wins.
    mode[7:6] = 2'b01;
    sig_in[3] = 1'b1; step();
    chk("t5_set_b3", 64'(if_b.flag[3]), 64'd1);
    sig_in[3] = 1'b0; step();
    sig_in[3] = 1'b1; flag_clr[3] = 1'b1; step();
    chk("t5_set_wins_b3", 64'(if_b.flag[3]), 64'd1);
    step();
    flag_clr[3] = 1'b0;
    chk("t5_clr_b3", 64'(if_b.flag[3]), 64'd0);

    // Channel 4 falling-edge mode, then switched off mid-stream.
    mode[9:8] = 2'b10;
    sig_in[4] = 1'b1; step();
    sig_in[4] = 1'b0; step();
    sig_in[4] = 1'b1; step();
    sig_in[4] = 1'b0; step();
    mode[9:8] = 2'b00;
    step();
    sig_in[4] = 1'b1; step();
    sig_in[4] = 1'b0; step();
    repeat (3) step();
    chk("t6_falls_b4", 64'(if_b.count[39:32]), 64'd2);

    // Reset in the middle of activity, then randomized traffic.
    do_reset();
    release_reset();
    for (int i = 0; i < 300; i++) begin
      sig_in   = NCH'($urandom);
      if ($urandom_range(0, 9) == 0) mode = (2*NCH)'($urandom);
      flag_clr = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      cnt_clr  = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      step();
      if (i == 150) begin
        do_reset();
        release_reset();
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
